fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0040_0000, PC value loaded by reset.
REQ-002 Parameter TEXT_BASE, default 32'h0040_0000, lowest valid instruction address.
REQ-003 Parameter IAW, default 10, word-address width; text window = 2**IAW words.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles waiting for imem_ack (range 1..255).
REQ-005 Parameter TRAP_VECTOR, default 32'h0040_0180, PC loaded on trap clear.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 stall  input  1  hold current instruction in EXEC.
REQ-009 jmp, jmp_target  input  1, 32  jump request and target.
REQ-010 br_taken, br_target  input  1, 32  taken branch and target.
REQ-011 trap_clr  input  1  leave TRAP and restart at TRAP_VECTOR.
REQ-012 imem_req  output  1  instruction memory request.
REQ-013 imem_addr  output  IAW  physical word address, (pc - TEXT_BASE) >> 2.
REQ-014 imem_ack, imem_rdata  input  1, 32  memory response and data.
REQ-015 pc, inst  output  32, 32  current PC and latched instruction.
REQ-016 inst_valid  output  1  inst valid for pc (EXEC state).
REQ-017 trap, cause  output  1, 2  trap flag; cause 0 none, 1 bad PC, 2 timeout.
REQ-018 retired  output  32  retired-instruction counter.

Function
REQ-019 FSM states SHALL be IDLE, REQ, EXEC, TRAP, encoded one-hot or binary freely.
REQ-020 bad_pc SHALL be pc[1:0]!=0, or pc<TEXT_BASE, or pc>=TEXT_BASE+4*2**IAW (compare unsigned, 33-bit to avoid wrap).
REQ-021 IDLE SHALL move to REQ after one cycle, no outputs active.
REQ-022 In REQ with bad_pc, imem_req SHALL be 0 and next state TRAP with cause 1.
REQ-023 In REQ with !bad_pc, imem_req SHALL be 1 and imem_addr valid combinationally from pc.
REQ-024 In REQ, imem_ack=1 SHALL latch imem_rdata into inst and move to EXEC next cycle (ack-to-valid latency 1).
REQ-025 A wait counter SHALL clear on entering REQ and increment each REQ cycle without ack; reaching TIMEOUT without ack SHALL go to TRAP with cause 2.
REQ-026 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL be accepted (ack wins).
REQ-027 In EXEC, inst_valid SHALL be 1; stall=1 SHALL hold pc, inst, state; redirect inputs ignored.
REQ-028 In EXEC with stall=0, pc SHALL update with priority jmp > br_taken > pc+4 (mod 2**32), retired SHALL increment by 1 (wraps), next state REQ.
REQ-029 In TRAP, trap=1, imem_req=0, inst_valid=0, pc frozen at faulting value, cause held.
REQ-030 trap_clr=1 in TRAP SHALL load pc=TRAP_VECTOR, cause=0, next state REQ; trap_clr outside TRAP ignored.
REQ-031 imem_ack outside REQ SHALL be ignored.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, pc=RESET_VECTOR, inst=0, retired=0, cause=0, wait counter=0, all request/valid/trap outputs 0.
REQ-033 rst asserted mid-request or in TRAP SHALL abandon the operation with no retire increment; first request follows 2 cycles after deassertion.

Verification
REQ-034 Reset release, ack same cycle as req, rdata 32'h2008_0005 -> imem_addr 0, inst_valid cycle 3 after release, pc 32'h0040_0000; no stall -> next req imem_addr 1.
REQ-035 EXEC with jmp=1 jmp_target 32'h0040_0100 and br_taken=1 -> pc 32'h0040_0100, imem_addr 64, retired+1.
REQ-036 br_target 32'h0040_1000 (IAW=10) -> next REQ no imem_req, trap=1, cause=1, pc 32'h0040_1000; trap_clr -> pc 32'h0040_0180, cause 0.
REQ-037 imem_ack held low TIMEOUT=15 cycles -> TRAP cause 2; variant ack on 15th cycle -> EXEC, no trap.
REQ-038 stall=1 for 4 EXEC cycles with jmp=1 -> pc, inst unchanged, retired unchanged; stall drop -> jump taken once.
REQ-039 rst pulse asynchronously mid-REQ (between edges) -> outputs at reset values before next edge; retired 0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetch sequencer with PC
//            validation, memory-ack timeout and trap/restart handling.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [31:0] TEXT_BASE    = 32'h0040_0000,
    parameter int          IAW          = 10,
    parameter int          TIMEOUT      = 15,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0040_0180
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           jmp,
    input  logic [31:0]    jmp_target,
    input  logic           br_taken,
    input  logic [31:0]    br_target,
    input  logic           trap_clr,
    output logic           imem_req,
    output logic [IAW-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [31:0]    imem_rdata,
    output logic [31:0]    pc,
    output logic [31:0]    inst,
    output logic           inst_valid,
    output logic           trap,
    output logic [1:0]     cause,
    output logic [31:0]    retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2,
        TRAP = 2'd3
    } state_t;

    localparam logic [1:0]  c_CAUSE_NONE    = 2'd0;
    localparam logic [1:0]  c_CAUSE_BADPC   = 2'd1;
    localparam logic [1:0]  c_CAUSE_TIMEOUT = 2'd2;
    // One past the last valid byte address; 33 bits so the window end cannot wrap.
    localparam logic [32:0] c_TEXT_END      = {1'b0, TEXT_BASE} + (33'd1 << (IAW + 2));
    localparam logic [8:0]  c_TIMEOUT       = 9'(TIMEOUT);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_retired;
    logic [1:0]  r_cause;
    logic [7:0]  r_waitCnt;

    logic        w_badPc;
    logic [8:0]  w_waitNext;
    logic [31:0] w_nextPc;

    assign w_badPc = (r_pc[1:0] != 2'b00)
                  || ({1'b0, r_pc} <  {1'b0, TEXT_BASE})
                  || ({1'b0, r_pc} >= c_TEXT_END);

    assign w_waitNext = {1'b0, r_waitCnt} + 9'd1;

    always_comb begin
        w_nextPc = r_pc + 32'd4;
        if (jmp) begin
            w_nextPc = jmp_target;
        end else if (br_taken) begin
            w_nextPc = br_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_VECTOR;
            r_inst    <= 32'd0;
            r_retired <= 32'd0;
            r_cause   <= c_CAUSE_NONE;
            r_waitCnt <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_waitCnt <= 8'd0;
                    r_state   <= REQ;
                end
                REQ: begin
                    // Ack is checked before the timeout so a last-cycle ack still wins.
                    if (w_badPc) begin
                        r_cause <= c_CAUSE_BADPC;
                        r_state <= TRAP;
                    end else if (imem_ack) begin
                        r_inst  <= imem_rdata;
                        r_state <= EXEC;
                    end else if (w_waitNext == c_TIMEOUT) begin
                        r_cause <= c_CAUSE_TIMEOUT;
                        r_state <= TRAP;
                    end else begin
                        r_waitCnt <= w_waitNext[7:0];
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        r_pc      <= w_nextPc;
                        r_retired <= r_retired + 32'd1;
                        r_waitCnt <= 8'd0;
                        r_state   <= REQ;
                    end
                end
                TRAP: begin
                    if (trap_clr) begin
                        r_pc      <= TRAP_VECTOR;
                        r_cause   <= c_CAUSE_NONE;
                        r_waitCnt <= 8'd0;
                        r_state   <= REQ;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so reset reaches them without a clock edge.
    assign imem_req   = (r_state == REQ) && !w_badPc;
    assign imem_addr  = IAW'((r_pc - TEXT_BASE) >> 2);
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_valid = (r_state == EXEC);
    assign trap       = (r_state == TRAP);
    assign cause      = r_cause;
    assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed plus randomized checking of fetch_unit against a
//            cycle-level behavioural reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] TEXT_BASE    = 32'h0040_0000;
    localparam int          IAW          = 10;
    localparam int          TIMEOUT      = 15;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0040_0180;

    logic           clk = 1'b0;
    logic           rst;
    logic           stall, jmp, br_taken, trap_clr, imem_ack;
    logic [31:0]    jmp_target, br_target, imem_rdata;
    logic           imem_req, inst_valid, trap;
    logic [IAW-1:0] imem_addr;
    logic [31:0]    pc, inst, retired;
    logic [1:0]     cause;

    int nChecks = 0;
    int nPass   = 0;

    // Reference: phase 0 idle, 1 fetching, 2 executing, 3 trapped
    int        mPhase, mWait, mCause;
    bit [31:0] mPc, mInst, mRetired;

    fetch_unit #(
        .RESET_VECTOR(RESET_VECTOR), .TEXT_BASE(TEXT_BASE), .IAW(IAW),
        .TIMEOUT(TIMEOUT), .TRAP_VECTOR(TRAP_VECTOR)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .jmp(jmp), .jmp_target(jmp_target),
        .br_taken(br_taken), .br_target(br_target), .trap_clr(trap_clr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc), .inst(inst), .inst_valid(inst_valid),
        .trap(trap), .cause(cause), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit isBad(input bit [31:0] a);
        longint unsigned p = longint'(a);
        longint unsigned lo = longint'(TEXT_BASE);
        return (p % 4 != 0) || (p < lo) || (p >= lo + 4 * (longint'(1) << IAW));
    endfunction

    task automatic modelReset();
        mPhase = 0; mWait = 0; mCause = 0;
        mPc = RESET_VECTOR; mInst = 0; mRetired = 0;
    endtask

    task automatic modelStep();
        case (mPhase)
            0: begin mPhase = 1; mWait = 0; end
            1: begin
                if (isBad(mPc)) begin
                    mPhase = 3; mCause = 1;
                end else if (imem_ack) begin
                    mInst = imem_rdata; mPhase = 2;
                end else begin
                    mWait++;
                    if (mWait == TIMEOUT) begin mPhase = 3; mCause = 2; end
                end
            end
            2: if (!stall) begin
                mPc = jmp ? jmp_target : (br_taken ? br_target : mPc + 32'd4);
                mRetired = mRetired + 32'd1;
                mPhase = 1; mWait = 0;
            end
            default: if (trap_clr) begin
                mPc = TRAP_VECTOR; mCause = 0; mPhase = 1; mWait = 0;
            end
        endcase
    endtask

    task automatic checkAll();
        bit expReq = (mPhase == 1) && !isBad(mPc);
        checkVal("imem_req", 32'(imem_req), 32'(expReq));
        if (expReq) checkVal("imem_addr", 32'(imem_addr), (mPc - TEXT_BASE) / 4);
        checkVal("pc", pc, mPc);
        checkVal("inst", inst, mInst);
        checkVal("inst_valid", 32'(inst_valid), 32'(mPhase == 2));
        checkVal("trap", 32'(trap), 32'(mPhase == 3));
        checkVal("cause", 32'(cause), 32'(mCause));
        checkVal("retired", retired, mRetired);
    endtask

    task automatic clearIn();
        stall = 0; jmp = 0; br_taken = 0; trap_clr = 0; imem_ack = 0;
        jmp_target = 0; br_target = 0; imem_rdata = 0;
    endtask

    // Called at a falling edge; inputs are already set for the coming rising edge.
    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkAll();
        clearIn();
    endtask

    // Asserts reset between edges and checks outputs before any clock edge.
    task automatic doReset();
        #2 rst = 1'b1;
        #1 modelReset();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
        clearIn();
    endtask

    function automatic logic [31:0] randTarget();
        case ($urandom_range(0, 19))
            0: return $urandom;
            1: return TEXT_BASE + 32'd4 * 32'((1 << IAW) - 1);
            2: return TEXT_BASE + 32'd4 * 32'(1 << IAW);
            3: return TEXT_BASE - 32'd4;
            4: return TEXT_BASE + 32'd2;
            default: return TEXT_BASE + 32'd4 * $urandom_range(0, (1 << IAW) - 1);
        endcase
    endfunction

    initial begin
        int ackPct;
        logic [31:0] pcHold, instHold, retHold;
        rst = 1'b1;
        clearIn();
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAll();
        rst = 1'b0;

        // Boot fetch: ack in the first request cycle
        tick();
        checkVal("boot_req", 32'(imem_req), 32'd1);
        checkVal("boot_addr", 32'(imem_addr), 32'd0);
        imem_ack = 1; imem_rdata = 32'h2008_0005;
        tick();
        checkVal("boot_inst", inst, 32'h2008_0005);
        checkVal("boot_valid", 32'(inst_valid), 32'd1);
        checkVal("boot_pc", pc, 32'h0040_0000);
        tick();
        checkVal("seq_addr", 32'(imem_addr), 32'd1);

        // Jump beats branch
        imem_ack = 1; imem_rdata = $urandom;
        tick();
        jmp = 1; jmp_target = 32'h0040_0100; br_taken = 1; br_target = 32'h0040_0200;
        tick();
        checkVal("jmp_pc", pc, 32'h0040_0100);
        checkVal("jmp_addr", 32'(imem_addr), 32'd64);

        // Branch out of the text window traps with cause 1
        imem_ack = 1; imem_rdata = $urandom;
        tick();
        br_taken = 1; br_target = 32'h0040_1000;
        tick();
        checkVal("bad_noreq", 32'(imem_req), 32'd0);
        imem_ack = 1;
        tick();
        checkVal("bad_trap", 32'(trap), 32'd1);
        checkVal("bad_cause", 32'(cause), 32'd1);
        checkVal("bad_pc", pc, 32'h0040_1000);
        trap_clr = 1;
        tick();
        checkVal("clr_pc", pc, 32'h0040_0180);
        checkVal("clr_cause", 32'(cause), 32'd0);

        // Timeout, then ack on the last permitted cycle
        repeat (TIMEOUT) tick();
        checkVal("to_trap", 32'(trap), 32'd1);
        checkVal("to_cause", 32'(cause), 32'd2);
        trap_clr = 1;
        tick();
        repeat (TIMEOUT - 1) tick();
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        checkVal("late_ack_valid", 32'(inst_valid), 32'd1);
        checkVal("late_ack_trap", 32'(trap), 32'd0);

        // Stall holds everything, redirect taken exactly once on release
        pcHold = pc; instHold = inst; retHold = retired;
        for (int i = 0; i < 4; i++) begin
            stall = 1; jmp = 1; jmp_target = 32'h0040_0300;
            tick();
        end
        checkVal("stall_pc", pc, pcHold);
        checkVal("stall_inst", inst, instHold);
        checkVal("stall_ret", retired, retHold);
        jmp = 1; jmp_target = 32'h0040_0300;
        tick();
        checkVal("unstall_pc", pc, 32'h0040_0300);
        checkVal("unstall_ret", retired, retHold + 32'd1);
        imem_ack = 1;
        tick();
        tick();
        checkVal("once_pc", pc, 32'h0040_0304);

        // Asynchronous reset while a request is pending
        doReset();
        checkVal("arst_ret", retired, 32'd0);
        checkVal("arst_req", 32'(imem_req), 32'd0);

        // Randomized traffic
        ackPct = 50;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: ackPct = 3;
                    1: ackPct = 40;
                    default: ackPct = 90;
                endcase
            end
            if ($urandom_range(0, 399) == 0) begin
                doReset();
            end else begin
                stall      = ($urandom_range(0, 3) == 0);
                jmp        = ($urandom_range(0, 5) == 0);
                jmp_target = randTarget();
                br_taken   = ($urandom_range(0, 3) == 0);
                br_target  = randTarget();
                trap_clr   = ($urandom_range(0, 2) == 0);
                imem_ack   = ($urandom_range(0, 99) < ackPct);
                imem_rdata = $urandom;
                tick();
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
